multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
//  execute, memory and writeback steps and drives every mux select and write
//  enable. It also selects sign- or zero-extension of the 16-bit immediate
//  (ext_sel) feeding the ALU B mux. It sits between the instruction register
//  (opcode/funct fields) and the datapath.
// PARAMETERS
//  MEM_WAIT  1  1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk        in   1  rising-edge clock
//  reset_n    in   1  asynchronous, active-low reset
//  opcode     in   6  instr[31:26] from IR
//  funct      in   6  instr[5:0] from IR
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access complete this cycle
//  pc_en      out  1  PC load = pc_write | (branch & zero)
//  iord       out  1  0: mem addr=PC, 1: mem addr=ALUOut
//  mem_write  out  1  memory write strobe
//  ir_write   out  1  load IR
//  reg_dst    out  1  0: rt, 1: rd
//  memtoreg   out  1  0: ALUOut, 1: MDR
//  reg_write  out  1  register file write enable
//  alu_src_a  out  1  0: PC, 1: regA
//  alu_src_b  out  2  00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
//  pc_src     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alu_ctrl   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  ext_sel    out  1  1: sign-extend imm, 0: zero-extend imm
//  illegal    out  1  one-cycle pulse in DECODE on unsupported opcode/funct
// BEHAVIOUR
//  - Moore FSM, state reg reset async to FETCH; outputs combinational from state
//    (+ zero, mem_ready). While reset_n=0 all enables (pc_en, mem_write, ir_write,
//    reg_write) and illegal are forced 0; selects = 0, alu_ctrl=010, ext_sel=1.
//  - FETCH: iord=0, src_a=0, src_b=01, alu add, pc_src=00. If mem_ready: ir_write=1,
//    pc_write=1, ->DECODE; else all enables 0, stay.
//  - DECODE: src_a=0, src_b=11, add (branch target to ALUOut). Next by opcode:
//    100011 lw / 101011 sw ->MEMADR; 000000 R ->RTYPEEX; 000100 beq ->BEQEX;
//    001000 addi, 001100 andi, 001101 ori ->IMMEX; 000010 j ->JEX;
//    else illegal=1, ->FETCH. R with funct not in {100000,100010,100100,100101,
//    101010} also illegal, ->FETCH.
//  - MEMADR: src_a=1, src_b=10, add, ext_sel=1; lw->MEMRD, sw->MEMWR.
//  - MEMRD: iord=1; ->MEMWB when mem_ready, else hold. MEMWB: reg_dst=0,
//    memtoreg=1, reg_write=1 ->FETCH.
//  - MEMWR: iord=1, mem_write=1 held until mem_ready cycle, then ->FETCH.
//  - RTYPEEX: src_a=1, src_b=00, alu_ctrl from funct ->RTYPEWB (reg_dst=1,
//    memtoreg=0, reg_write=1) ->FETCH.
//  - IMMEX: src_a=1, src_b=10; addi: add, ext_sel=1; andi: and, ext_sel=0; ori:
//    or, ext_sel=0 ->IMMWB (reg_dst=0, memtoreg=0, reg_write=1) ->FETCH.
//  - BEQEX: src_a=1, src_b=00, sub, pc_src=01, branch=1 (pc_en=zero) ->FETCH.
//  - JEX: pc_src=10, pc_write=1 ->FETCH.
//  - Latency with mem_ready=1: lw 5, sw 4, R 4, imm 4, beq 3, j 3 cycles.
//  - ext_sel and alu_ctrl are held stable for every cycle of a state; ext_sel=1
//    outside IMMEX for andi/ori. Unused encodings of state reg ->FETCH.
//  - Opcode latched in IR: controller holds an internal copy captured in DECODE
//    so later states do not depend on IR after DECODE.
//  - reset_n low mid-instruction: immediate return to FETCH; no partial writes.
// TESTING
//  - Reset then lw (op 100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,
//    MEMWB; reg_write=1, memtoreg=1 only in cycle 5.
//  - sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, 1 FETCH after.
//  - beq zero=1 -> pc_en=1 in BEQEX with pc_src=01; zero=0 -> pc_en=0.
//  - andi/ori -> ext_sel=0, alu_ctrl 000/001 in IMMEX; addi -> ext_sel=1, alu 010.
//  - opcode 111111 -> illegal pulses 1 cycle in DECODE, next state FETCH, no writes.
//  - reset_n low during RTYPEEX -> enables 0 at once; after release, FETCH, no reg_write.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module multicycle_ctrl #(
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       memtoreg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl,
    output logic       ext_sel,
    output logic       illegal
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_IMMEX   = 4'd8;
    localparam logic [3:0] S_IMMWB   = 4'd9;
    localparam logic [3:0] S_BEQEX   = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] r_state;
    logic [5:0] r_op;
    logic [5:0] r_funct;
    logic [3:0] w_next;
    logic       w_rdy;
    logic       w_funct_ok;
    logic       w_legal;
    logic       w_pc_write;
    logic       w_branch;

    assign w_rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_funct_ok = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_funct_ok = 1'b1;
            default:                          w_funct_ok = 1'b0;
        endcase
        w_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: w_legal = 1'b1;
            OP_R:    w_legal = w_funct_ok;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             w_next = S_MEMADR;
                    OP_R:                     w_next = w_funct_ok ? S_RTYPEEX : S_FETCH;
                    OP_BEQ:                   w_next = S_BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMMEX;
                    OP_J:                     w_next = S_JEX;
                    default:                  w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_IMMEX:   w_next = S_IMMWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Opcode/funct are captured in DECODE so later states no longer depend on the IR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_op    <= 6'd0;
            r_funct <= 6'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= opcode;
                r_funct <= funct;
            end
        end
    end

    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        memtoreg   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_ADD;
        ext_sel    = 1'b1;
        illegal    = 1'b0;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        // Reset forces the idle control word regardless of the state register.
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    alu_src_b  = 2'b01;
                    ir_write   = w_rdy;
                    w_pc_write = w_rdy;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    illegal   = ~w_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    memtoreg  = 1'b1;
                    reg_write = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_RTYPEEX: begin
                    alu_src_a = 1'b1;
                    case (r_funct)
                        F_SUB:   alu_ctrl = ALU_SUB;
                        F_AND:   alu_ctrl = ALU_AND;
                        F_OR:    alu_ctrl = ALU_OR;
                        F_SLT:   alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                S_RTYPEWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_IMMEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (r_op)
                        OP_ANDI: begin alu_ctrl = ALU_AND; ext_sel = 1'b0; end
                        OP_ORI:  begin alu_ctrl = ALU_OR;  ext_sel = 1'b0; end
                        default: begin alu_ctrl = ALU_ADD; ext_sel = 1'b1; end
                    endcase
                end
                S_IMMWB: reg_write = 1'b1;
                S_BEQEX: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    w_branch  = 1'b1;
                end
                S_JEX: begin
                    pc_src     = 2'b10;
                    w_pc_write = 1'b1;
                end
                default: ;
            endcase
        end
        pc_en = w_pc_write | (w_branch & zero);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected control word
// for every cycle it drives, and a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memtoreg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       ext_sel;
        logic       illegal;
    } ctrl_t;

    typedef enum {K_LW, K_SW, K_R, K_BEQ, K_IMM, K_J, K_BAD} kind_e;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, memtoreg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       ext_sel, illegal;

    ctrl_t exp_q[$];
    string tag_q[$];
    bit    mon_en = 1'b0;
    int    checks = 0;
    int    errors = 0;

    multicycle_ctrl #(.MEM_WAIT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .memtoreg(memtoreg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_ctrl(alu_ctrl),
        .ext_sel(ext_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: instruction semantics expressed as opcode/funct tables.
    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b001000, 6'b001100, 6'b001101: return K_IMM;
            6'b000000: begin
                if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                    fn == 6'b100101 || fn == 6'b101010) return K_R;
                return K_BAD;
            end
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic ctrl_t idle_w();
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = 3'b010;
        c.ext_sel  = 1'b1;
        return c;
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom());
    endfunction

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            ctrl_t got, e;
            string t;
            got = '{pc_en, iord, mem_write, ir_write, reg_dst, memtoreg, reg_write,
                    alu_src_a, alu_src_b, pc_src, alu_ctrl, ext_sel, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: DUT word %h with no expectation queued", got);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s at %0t: got %h expected %h", t, $time, got, e);
                end
            end
        end
    end

    task automatic cyc(input ctrl_t e, input string tag, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic z);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int fst);
        ctrl_t e;
        e           = idle_w();
        e.alu_src_b = 2'b01;
        for (int i = 0; i < fst; i++) cyc(e, "fetch_wait", r6(), r6(), 1'b0, rb());
        e.pc_en    = 1'b1;
        e.ir_write = 1'b1;
        cyc(e, "fetch", r6(), r6(), 1'b1, rb());
        e           = idle_w();
        e.alu_src_b = 2'b11;
        e.illegal   = (classify(op, fn) == K_BAD);
        cyc(e, "decode", op, fn, rb(), rb());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fst, input int mst);
        ctrl_t e;
        kind_e k;
        k = classify(op, fn);
        fetch_decode(op, fn, fst);
        case (k)
            K_LW, K_SW: begin
                e           = idle_w();
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                cyc(e, "memadr", r6(), r6(), rb(), rb());
                e           = idle_w();
                e.iord      = 1'b1;
                e.mem_write = (k == K_SW);
                for (int i = 0; i < mst; i++)
                    cyc(e, (k == K_SW) ? "memwr_wait" : "memrd_wait", r6(), r6(), 1'b0, rb());
                cyc(e, (k == K_SW) ? "memwr" : "memrd", r6(), r6(), 1'b1, rb());
                if (k == K_LW) begin
                    e           = idle_w();
                    e.memtoreg  = 1'b1;
                    e.reg_write = 1'b1;
                    cyc(e, "memwb", r6(), r6(), rb(), rb());
                end
            end
            K_R: begin
                e           = idle_w();
                e.alu_src_a = 1'b1;
                e.alu_ctrl  = alu_for_funct(fn);
                cyc(e, "rtypeex", r6(), r6(), rb(), rb());
                e           = idle_w();
                e.reg_dst   = 1'b1;
                e.reg_write = 1'b1;
                cyc(e, "rtypewb", r6(), r6(), rb(), rb());
            end
            K_IMM: begin
                e           = idle_w();
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                if (op == 6'b001100) begin e.alu_ctrl = 3'b000; e.ext_sel = 1'b0; end
                if (op == 6'b001101) begin e.alu_ctrl = 3'b001; e.ext_sel = 1'b0; end
                cyc(e, "immex", r6(), r6(), rb(), rb());
                e           = idle_w();
                e.reg_write = 1'b1;
                cyc(e, "immwb", r6(), r6(), rb(), rb());
            end
            K_BEQ: begin
                e           = idle_w();
                e.alu_src_a = 1'b1;
                e.alu_ctrl  = 3'b110;
                e.pc_src    = 2'b01;
                e.pc_en     = z;
                cyc(e, "beqex", r6(), r6(), rb(), z);
            end
            K_J: begin
                e        = idle_w();
                e.pc_src = 2'b10;
                e.pc_en  = 1'b1;
                cyc(e, "jex", r6(), r6(), rb(), rb());
            end
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[10];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b001100, 6'b001101, 6'b000010, 6'b111111, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(idle_w(), "reset", r6(), r6(), rb(), rb());
        cyc(idle_w(), "reset", r6(), r6(), rb(), rb());
        reset_n = 1'b1;

        // Directed cases
        run_instr(6'b100011, r6(), 1'b0, 0, 0);           // lw, 5 cycles
        run_instr(6'b101011, r6(), 1'b0, 0, 3);           // sw, mem_write 4 cycles
        run_instr(6'b000100, r6(), 1'b1, 0, 0);           // beq taken
        run_instr(6'b000100, r6(), 1'b0, 0, 0);           // beq not taken
        run_instr(6'b001100, r6(), 1'b0, 0, 0);           // andi
        run_instr(6'b001101, r6(), 1'b0, 0, 0);           // ori
        run_instr(6'b001000, r6(), 1'b0, 0, 0);           // addi
        run_instr(6'b111111, r6(), 1'b0, 0, 0);           // illegal opcode
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);      // illegal funct
        run_instr(6'b000010, r6(), 1'b0, 1, 0);           // j with fetch stall

        // Reset asserted while in RTYPEEX
        fetch_decode(6'b000000, 6'b100010, 0);
        reset_n = 1'b0;
        cyc(idle_w(), "reset_rtypeex", r6(), r6(), rb(), rb());
        cyc(idle_w(), "reset_hold", r6(), r6(), rb(), rb());
        reset_n = 1'b1;
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) op = r6();
            fn = ($urandom_range(0, 4) == 0) ? r6() : fns[$urandom_range(0, 4)];
            run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
